// File: rtl/adpll_pkg.sv
// Shared encodings and reset defaults for the bang-bang ADPLL core.
package adpll_pkg;

  // Phase-detector error, two's-complement in 2 bits.
  typedef enum logic [1:0] {
    E_ZERO = 2'b00,
    E_POS  = 2'b01,
    E_NEG  = 2'b11
  } err_t;

  localparam logic [2:0] SEL_KP   = 3'd0;
  localparam logic [2:0] SEL_KI   = 3'd1;
  localparam logic [2:0] SEL_LTHR = 3'd2;
  localparam logic [2:0] SEL_FCW0 = 3'd3;

  localparam int unsigned KP_RST   = 4;
  localparam int unsigned KI_RST   = 1;
  localparam int unsigned LTHR_RST = 16;

  // Bang-bang decision on the sampled NCO phase.
  function automatic err_t bbpd(input logic late, input logic nonzero);
    if (late)
      return E_POS;
    else if (nonzero)
      return E_NEG;
    else
      return E_ZERO;
  endfunction

endpackage

// File: rtl/adpll_sync2.sv
// Two-flop synchroniser for asynchronous pin inputs.
module adpll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adpll_bbpd_core.sv
// ADPLL loop engine: bang-bang PD, PI filter with saturation, clamped NCO,
// lock detector, programmable register file and registered readback.
module adpll_bbpd_core
  import adpll_pkg::*;
#(
  parameter int unsigned      ACC_W   = 16,
  parameter int unsigned      CTRL_W  = 12,
  parameter int unsigned      PGM_W   = 5,
  parameter logic [ACC_W-1:0] FCW_DEF = 16'h1000,
  parameter int unsigned      LCNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             ref_in,
  input  logic             clr,
  input  logic             pgm,
  input  logic [2:0]       param_sel,
  input  logic [PGM_W-1:0] pgm_value,
  input  logic             out_sel,
  output logic             nco_clk,
  output logic             fb_clk,
  output logic [PGM_W-1:0] dout,
  output logic             sign,
  output logic             locked
);

  localparam int unsigned SW = ACC_W + 2;
  localparam int unsigned IW = ((CTRL_W > PGM_W) ? CTRL_W : PGM_W) + 2;

  localparam logic signed [SW-1:0] FCW_MAX = {3'b001, {(ACC_W-1){1'b0}}};
  localparam logic signed [SW-1:0] FCW_MIN = SW'(1);
  localparam logic signed [IW-1:0] INT_MAX = {{(IW-CTRL_W+1){1'b0}}, {(CTRL_W-1){1'b1}}};
  localparam logic signed [IW-1:0] INT_MIN = {{(IW-CTRL_W+1){1'b1}}, {(CTRL_W-1){1'b0}}};

  logic ref_s, clr_s, pgm_s;
  logic ref_d, pgm_d;
  logic ref_edge, pgm_edge;

  logic [ACC_W-1:0]         phase;
  logic [ACC_W-1:0]         fcw_nom;
  logic [ACC_W-1:0]         fcw;
  logic signed [CTRL_W-1:0] integ;
  err_t                     e;
  logic [LCNT_W-1:0]        lcnt;
  logic [LCNT_W-1:0]        lthr;
  logic [PGM_W-1:0]         kp;
  logic [PGM_W-1:0]         ki;

  adpll_sync2 u_sync_ref (.clk(clk), .rst_n(rst_n), .d(ref_in), .q(ref_s));
  adpll_sync2 u_sync_clr (.clk(clk), .rst_n(rst_n), .d(clr),    .q(clr_s));
  adpll_sync2 u_sync_pgm (.clk(clk), .rst_n(rst_n), .d(pgm),    .q(pgm_s));

  // Edge detectors run regardless of ena so a freeze does not fabricate edges on resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_d <= 1'b0;
      pgm_d <= 1'b0;
    end else begin
      ref_d <= ref_s;
      pgm_d <= pgm_s;
    end
  end

  assign ref_edge = ref_s & ~ref_d;
  assign pgm_edge = pgm_s & ~pgm_d;

  logic signed [SW-1:0] fcw_sum;
  logic signed [SW-1:0] kp_term;

  always_comb begin
    kp_term = '0;
    if (e == E_POS)
      kp_term = $signed({{(SW-PGM_W){1'b0}}, kp});
    else if (e == E_NEG)
      kp_term = -$signed({{(SW-PGM_W){1'b0}}, kp});
    fcw_sum = $signed({2'b00, fcw_nom})
            + $signed({{(SW-CTRL_W){integ[CTRL_W-1]}}, integ})
            + kp_term;
    if (fcw_sum < FCW_MIN)
      fcw = FCW_MIN[ACC_W-1:0];
    else if (fcw_sum > FCW_MAX)
      fcw = FCW_MAX[ACC_W-1:0];
    else
      fcw = fcw_sum[ACC_W-1:0];
  end

  err_t                     e_new;
  logic signed [IW-1:0]     ki_term;
  logic signed [IW-1:0]     integ_sum;
  logic signed [CTRL_W-1:0] integ_next;
  logic                     lock_hit;
  logic [LCNT_W-1:0]        lcnt_inc;

  always_comb begin
    e_new   = bbpd(phase[ACC_W-1], |phase);
    ki_term = '0;
    if (e_new == E_POS)
      ki_term = $signed({{(IW-PGM_W){1'b0}}, ki});
    else if (e_new == E_NEG)
      ki_term = -$signed({{(IW-PGM_W){1'b0}}, ki});
    integ_sum = $signed({{(IW-CTRL_W){integ[CTRL_W-1]}}, integ}) + ki_term;
    if (integ_sum > INT_MAX)
      integ_next = INT_MAX[CTRL_W-1:0];
    else if (integ_sum < INT_MIN)
      integ_next = INT_MIN[CTRL_W-1:0];
    else
      integ_next = integ_sum[CTRL_W-1:0];
    lock_hit = ((e_new == E_POS) && (e == E_NEG)) || ((e_new == E_NEG) && (e == E_POS));
    lcnt_inc = (lcnt == '1) ? lcnt : lcnt + LCNT_W'(1);
  end

  // Loop state; the old gains are used on a cycle that also carries a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= '0;
      integ  <= '0;
      e      <= E_ZERO;
      lcnt   <= '0;
      locked <= 1'b0;
    end else if (ena) begin
      if (clr_s) begin
        phase  <= '0;
        integ  <= '0;
        e      <= E_ZERO;
        lcnt   <= '0;
        locked <= 1'b0;
      end else begin
        phase  <= phase + fcw;
        locked <= (lcnt >= lthr);
        if (ref_edge) begin
          e     <= e_new;
          integ <= integ_next;
          lcnt  <= lock_hit ? lcnt_inc : '0;
        end
      end
    end
  end

  logic [2:0]       slice_k;
  logic [ACC_W-1:0] slice_mask;
  logic [ACC_W-1:0] slice_data;

  // fcw_nom is written PGM_W bits at a time; bits shifted past ACC_W simply fall off.
  always_comb begin
    slice_k    = param_sel - SEL_FCW0;
    slice_mask = ACC_W'({PGM_W{1'b1}}) << (int'(slice_k) * PGM_W);
    slice_data = ACC_W'(pgm_value) << (int'(slice_k) * PGM_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp      <= PGM_W'(KP_RST);
      ki      <= PGM_W'(KI_RST);
      lthr    <= LCNT_W'(LTHR_RST);
      fcw_nom <= FCW_DEF;
    end else if (ena && !clr_s && pgm_edge) begin
      case (param_sel)
        SEL_KP:   kp   <= pgm_value;
        SEL_KI:   ki   <= pgm_value;
        SEL_LTHR: lthr <= LCNT_W'(pgm_value);
        default:  fcw_nom <= (fcw_nom & ~slice_mask) | slice_data;
      endcase
    end
  end

  logic [PGM_W-1:0]  rb_reg;
  logic [CTRL_W-1:0] integ_abs;
  logic              unused_abs;

  always_comb begin
    case (param_sel)
      SEL_KP:   rb_reg = kp;
      SEL_KI:   rb_reg = ki;
      SEL_LTHR: rb_reg = PGM_W'(lthr);
      default:  rb_reg = PGM_W'(fcw_nom >> (int'(slice_k) * PGM_W));
    endcase
    integ_abs = integ[CTRL_W-1] ? -integ : integ;
  end

  assign unused_abs = ^integ_abs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      sign <= 1'b0;
    end else if (ena) begin
      if (out_sel) begin
        dout <= rb_reg;
        sign <= locked;
      end else begin
        dout <= integ_abs[CTRL_W-2 -: PGM_W];
        sign <= integ[CTRL_W-1];
      end
    end
  end

  assign nco_clk = phase[ACC_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fb_clk <= 1'b0;
    else
      fb_clk <= nco_clk;
  end

endmodule

// File: tb/tb_adpll_bbpd_core.sv
// Directed bench for adpll_bbpd_core: reset, programming, open-loop NCO,
// PD/PI step, integrator saturation, lock detect, clr and ena freeze.
module tb_adpll_bbpd_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       ref_in = 1'b0;
  logic       clr = 1'b0;
  logic       pgm = 1'b0;
  logic [2:0] param_sel = 3'd0;
  logic [4:0] pgm_value = 5'd0;
  logic       out_sel = 1'b1;
  logic       nco_clk, fb_clk, sign, locked;
  logic [4:0] dout;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  adpll_bbpd_core dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ref_in(ref_in), .clr(clr), .pgm(pgm),
    .param_sel(param_sel), .pgm_value(pgm_value), .out_sel(out_sel),
    .nco_clk(nco_clk), .fb_clk(fb_clk), .dout(dout), .sign(sign), .locked(locked)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] sel, input logic [4:0] val);
    param_sel = sel;
    pgm_value = val;
    pgm = 1'b1;
    tick(3);
    pgm = 1'b0;
    tick(3);
  endtask

  task automatic clear_loop();
    clr = 1'b1;
    tick(4);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; out_sel = 1'b1; param_sel = 3'd0;
    tick(3);
    n_tests++; if (nco_clk !== 1'b0) begin n_fail++; $display("FAIL reset_nco_clk got=%b exp=0", nco_clk); end
    n_tests++; if (fb_clk !== 1'b0) begin n_fail++; $display("FAIL reset_fb_clk got=%b exp=0", fb_clk); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", locked); end
    n_tests++; if (dout !== 5'd0) begin n_fail++; $display("FAIL reset_dout got=%0d exp=0", dout); end
    n_tests++; if (sign !== 1'b0) begin n_fail++; $display("FAIL reset_sign got=%b exp=0", sign); end
    rst_n = 1'b1;
    tick(2);
    n_tests++; if (dout !== 5'd4) begin n_fail++; $display("FAIL reset_kp_readback got=%0d exp=4", dout); end
    n_tests++; if (sign !== 1'b0) begin n_fail++; $display("FAIL reset_lock_readback got=%b exp=0", sign); end
  endtask

  task automatic test_open_loop();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      tick(1);
      n_tests++;
      if (nco_clk !== ((n % 16) >= 8)) begin
        n_fail++; $display("FAIL open_loop_nco cycle=%0d got=%b exp=%b", n, nco_clk, ((n % 16) >= 8));
      end
      n_tests++;
      if (fb_clk !== (((n - 1) % 16) >= 8)) begin
        n_fail++; $display("FAIL open_loop_fb cycle=%0d got=%b exp=%b", n, fb_clk, (((n - 1) % 16) >= 8));
      end
    end
  endtask

  task automatic test_program();
    out_sel = 1'b1; param_sel = 3'd1; pgm_value = 5'd3;
    tick(1);
    n_tests++; if (dout !== 5'd1) begin n_fail++; $display("FAIL program_ki_before got=%0d exp=1", dout); end
    pgm = 1'b1;
    tick(4);
    n_tests++; if (dout !== 5'd3) begin n_fail++; $display("FAIL program_ki_after got=%0d exp=3", dout); end
    pgm = 1'b0;
    tick(3);
  endtask

  // KI=3, KP=4, fcw_nom=0x1000: ref edge lands while phase is 0x9000.
  task automatic test_pd_pi();
    clear_loop();
    tick(9);
    ref_in = 1'b1;
    tick(2);
    n_tests++; if (dut.phase !== 16'h9000) begin n_fail++; $display("FAIL pd_phase_pre got=%h exp=9000", dut.phase); end
    n_tests++; if (dut.e !== 2'b00) begin n_fail++; $display("FAIL pd_e_pre got=%b exp=00", dut.e); end
    tick(1);
    n_tests++; if (dut.e !== 2'b01) begin n_fail++; $display("FAIL pd_e got=%b exp=01", dut.e); end
    n_tests++; if (dut.integ !== 12'sd3) begin n_fail++; $display("FAIL pd_integ got=%0d exp=3", dut.integ); end
    n_tests++; if (dut.phase !== 16'hA000) begin n_fail++; $display("FAIL pd_phase_edge got=%h exp=a000", dut.phase); end
    tick(1);
    n_tests++; if (dut.phase !== 16'hB007) begin n_fail++; $display("FAIL pd_phase_new_fcw got=%h exp=b007", dut.phase); end
  endtask

  // fcw_nom=0x8000 keeps phase toggling 0/0x8000; edges every 4 cycles always see 0x8000.
  task automatic test_saturation();
    ref_in = 1'b0;
    write_reg(3'd1, 5'd31);
    write_reg(3'd5, 5'd0);
    write_reg(3'd6, 5'd1);
    clear_loop();
    tick(5);
    for (int k = 0; k < 3000; k++) begin
      ref_in = 1'b1;
      tick(2);
      ref_in = 1'b0;
      tick(2);
    end
    n_tests++; if (dut.integ !== 12'sd2047) begin n_fail++; $display("FAIL sat_integ got=%0d exp=2047", dut.integ); end
    n_tests++; if (dut.e !== 2'b01) begin n_fail++; $display("FAIL sat_e got=%b exp=01", dut.e); end
    n_tests++; if (dut.phase !== 16'h8000) begin n_fail++; $display("FAIL sat_phase_a got=%h exp=8000", dut.phase); end
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sat_locked got=%b exp=0", locked); end
    out_sel = 1'b0;
    tick(1);
    n_tests++; if (dut.phase !== 16'h0000) begin n_fail++; $display("FAIL sat_phase_b got=%h exp=0000", dut.phase); end
    n_tests++; if (dout !== 5'd31) begin n_fail++; $display("FAIL sat_dout got=%0d exp=31", dout); end
    n_tests++; if (sign !== 1'b0) begin n_fail++; $display("FAIL sat_sign got=%b exp=0", sign); end
  endtask

  // Open loop at fcw=0x4000 with a 6-cycle ref: samples alternate 0x4000 / 0xC000.
  task automatic test_lock_clr();
    write_reg(3'd0, 5'd0);
    write_reg(3'd1, 5'd0);
    write_reg(3'd2, 5'd8);
    write_reg(3'd5, 5'd16);
    write_reg(3'd6, 5'd0);
    out_sel = 1'b1; param_sel = 3'd2;
    clear_loop();
    tick(5);
    for (int k = 1; k <= 9; k++) begin
      ref_in = 1'b1;
      tick(3);
      ref_in = 1'b0;
      tick(3);
      if (k == 8) begin
        n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got=%b exp=0", locked); end
        n_tests++; if (dut.lcnt !== 6'd7) begin n_fail++; $display("FAIL lock_lcnt7 got=%0d exp=7", dut.lcnt); end
      end
    end
    n_tests++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_set got=%b exp=1", locked); end
    n_tests++; if (dut.lcnt !== 6'd8) begin n_fail++; $display("FAIL lock_lcnt8 got=%0d exp=8", dut.lcnt); end
    n_tests++; if (dut.e !== 2'b11) begin n_fail++; $display("FAIL lock_e got=%b exp=11", dut.e); end
    n_tests++; if (sign !== 1'b1) begin n_fail++; $display("FAIL lock_sign got=%b exp=1", sign); end
    n_tests++; if (dout !== 5'd8) begin n_fail++; $display("FAIL lock_lthr_rb got=%0d exp=8", dout); end
    clr = 1'b1;
    tick(4);
    n_tests++; if (locked !== 1'b0) begin n_fail++; $display("FAIL clr_locked got=%b exp=0", locked); end
    n_tests++; if (dut.lcnt !== 6'd0) begin n_fail++; $display("FAIL clr_lcnt got=%0d exp=0", dut.lcnt); end
    n_tests++; if (dut.e !== 2'b00) begin n_fail++; $display("FAIL clr_e got=%b exp=00", dut.e); end
    n_tests++; if (dut.integ !== 12'sd0) begin n_fail++; $display("FAIL clr_integ got=%0d exp=0", dut.integ); end
    n_tests++; if (dut.phase !== 16'h0000) begin n_fail++; $display("FAIL clr_phase got=%h exp=0000", dut.phase); end
    n_tests++; if (sign !== 1'b0) begin n_fail++; $display("FAIL clr_sign got=%b exp=0", sign); end
    clr = 1'b0;
    tick(4);
    ena = 1'b0;
    tick(5);
    n_tests++; if (dut.phase !== 16'h8000) begin n_fail++; $display("FAIL hold_phase got=%h exp=8000", dut.phase); end
    n_tests++; if (nco_clk !== 1'b1) begin n_fail++; $display("FAIL hold_nco got=%b exp=1", nco_clk); end
    ena = 1'b1;
    tick(1);
    n_tests++; if (dut.phase !== 16'hC000) begin n_fail++; $display("FAIL resume_phase got=%h exp=c000", dut.phase); end
    n_tests++; if (dout !== 5'd8) begin n_fail++; $display("FAIL clr_keeps_lthr got=%0d exp=8", dout); end
  endtask

  initial begin
    test_reset();
    test_open_loop();
    test_program();
    test_pd_pi();
    test_saturation();
    test_lock_clr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
